// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, BTB entry layout and saturating-counter constants.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int TAG_W_MAX = 30;
  localparam int CNT_W_MAX = 8;
  localparam int CNT_W_DEF = 2;

  // Tag and counter fields use the widest legal size; narrower configurations zero-extend.
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    word_t                target;
    logic [CNT_W_MAX-1:0] counter;
  } btb_entry_t;

  function automatic logic [CNT_W_MAX-1:0] cnt_weak_taken(input int w);
    return CNT_W_MAX'(1 << (w - 1));
  endfunction

  function automatic logic [CNT_W_MAX-1:0] cnt_max(input int w);
    return CNT_W_MAX'((1 << w) - 1);
  endfunction

  localparam logic [CNT_W_MAX-1:0] CNT_WEAK_TAKEN = cnt_weak_taken(CNT_W_DEF);
  localparam logic [CNT_W_MAX-1:0] CNT_MAX        = cnt_max(CNT_W_DEF);

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: two combinational read ports (lookup, update) and one
// synchronous write port; whole array cleared by synchronous RST.
module btb_array
  import cpu_types_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] lu_idx,
  output btb_entry_t       lu_entry,
  input  logic [IDX_W-1:0] up_idx,
  output btb_entry_t       up_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  btb_entry_t       wr_entry
);

  btb_entry_t mem [ENTRIES];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

  assign lu_entry = mem[lu_idx];
  assign up_entry = mem[up_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch PC generator with BTB-based next-PC prediction and EX-stage redirect.
// Optional BPU_STATS_EN adds saturating branch/mispredict counters.
module branch_predict_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT     = 32'h0,
  parameter int    BTB_ENTRIES = 16,
  parameter int    CNT_W       = 2
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  pc_en,
  input  logic  halt,
  output word_t pc_out,
  output logic  pred_taken,
  output word_t pred_target,
  input  logic  ex_valid,
  input  logic  ex_is_branch,
  input  word_t ex_pc,
  input  logic  ex_taken,
  input  word_t ex_target,
  input  logic  ex_pred_taken,
  input  word_t ex_pred_target,
  output logic  flush
`ifdef BPU_STATS_EN
  ,
  output word_t branch_cnt,
  output word_t mispredict_cnt
`endif
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam logic [CNT_W_MAX-1:0] C_WEAK = cnt_weak_taken(CNT_W);
  localparam logic [CNT_W_MAX-1:0] C_MAX  = cnt_max(CNT_W);

  btb_entry_t lu_entry, up_entry, wr_entry;
  logic       wr_en;
  logic [TAG_W_MAX-1:0] lu_tag, up_tag;
  logic       lu_hit, up_hit, ex_branch, mispredict;
  word_t      pc_plus4;

  assign lu_tag = {{IDX_W{1'b0}}, pc_out[31:IDX_W+2]};
  assign up_tag = {{IDX_W{1'b0}}, ex_pc[31:IDX_W+2]};

  btb_array #(.ENTRIES(BTB_ENTRIES), .IDX_W(IDX_W)) u_btb (
    .CLK      (CLK),
    .RST      (RST),
    .lu_idx   (pc_out[IDX_W+1:2]),
    .lu_entry (lu_entry),
    .up_idx   (ex_pc[IDX_W+1:2]),
    .up_entry (up_entry),
    .wr_en    (wr_en),
    .wr_idx   (ex_pc[IDX_W+1:2]),
    .wr_entry (wr_entry)
  );

  // Counter never exceeds C_MAX, so ">= C_WEAK" is the same as testing its MSB.
  assign lu_hit      = lu_entry.valid && (lu_entry.tag == lu_tag);
  assign pc_plus4    = pc_out + 32'd4;
  assign pred_taken  = lu_hit && (lu_entry.counter >= C_WEAK);
  assign pred_target = pred_taken ? lu_entry.target : pc_plus4;

  assign ex_branch  = ex_valid && ex_is_branch;
  assign mispredict = ex_branch &&
                      ((ex_taken != ex_pred_taken) || (ex_taken && (ex_target != ex_pred_target)));
  assign flush      = mispredict;

  assign up_hit = up_entry.valid && (up_entry.tag == up_tag);

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = up_entry;
    if (ex_branch) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (ex_taken) begin
          wr_entry.target = ex_target;
          if (up_entry.counter != C_MAX) wr_entry.counter = up_entry.counter + 1'b1;
        end else if (up_entry.counter != '0) begin
          wr_entry.counter = up_entry.counter - 1'b1;
        end
      end else if (ex_taken) begin
        wr_en            = 1'b1;
        wr_entry.valid   = 1'b1;
        wr_entry.tag     = up_tag;
        wr_entry.target  = ex_target;
        wr_entry.counter = C_WEAK;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST)             pc_out <= PC_INIT;
    else if (mispredict) pc_out <= ex_taken ? ex_target : ex_pc + 32'd4;
    else if (halt)       pc_out <= pc_out;
    else if (pc_en)      pc_out <= pred_target;
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (ex_branch && (branch_cnt != '1))     branch_cnt     <= branch_cnt + 32'd1;
      if (mispredict && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit; expected fetch addresses go through a queue.
module tb_branch_predict_unit;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  logic  RST, pc_en, halt;
  word_t pc_out, pred_target;
  logic  pred_taken, flush;
  logic  ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
  word_t ex_pc, ex_target, ex_pred_target;
`ifdef BPU_STATS_EN
  word_t branch_cnt, mispredict_cnt;
`endif

  word_t exp_q[$];
  word_t exp_pc;
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 CLK = ~CLK;

  branch_predict_unit #(.PC_INIT(32'h0), .BTB_ENTRIES(16), .CNT_W(2)) dut (
    .CLK(CLK), .RST(RST), .pc_en(pc_en), .halt(halt),
    .pc_out(pc_out), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .flush(flush)
`ifdef BPU_STATS_EN
    , .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
`endif
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ex();
    ex_valid = 0; ex_is_branch = 0; ex_pc = '0; ex_taken = 0;
    ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  task automatic set_ex(input word_t pc, input logic tk, input word_t tgt,
                        input logic ptk, input word_t ptgt);
    ex_valid = 1; ex_is_branch = 1; ex_pc = pc; ex_taken = tk;
    ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  // Not-taken resolution of a branch predicted taken at addr-4 steers fetch to addr.
  task automatic redirect_to(input word_t addr);
    set_ex(addr - 32'd4, 1'b0, 32'h0BAD_0000, 1'b1, 32'h0BAD_0000);
    exp_q.push_back(addr);
    step();
    clear_ex();
    exp_pc = exp_q.pop_front();
    n_checks++;
    if (pc_out !== exp_pc) begin
      n_errors++;
      $display("FAIL redirect: pc_out=%h expected %h", pc_out, exp_pc);
    end
  endtask

  task automatic test_reset();
    RST = 1; pc_en = 0; halt = 0; clear_ex();
    step();
    RST = 0;
    n_checks++; if (pc_out !== 32'h0) begin n_errors++; $display("FAIL reset_pc: pc_out=%h expected %h", pc_out, 32'h0); end
    n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken); end
    n_checks++; if (pred_target !== 32'h4) begin n_errors++; $display("FAIL reset_pred_target: got %h expected %h", pred_target, 32'h4); end
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
    pc_en = 1;
    for (int i = 1; i <= 3; i++) begin
      exp_q.push_back(word_t'(4 * i));
      step();
      exp_pc = exp_q.pop_front();
      n_checks++;
      if (pc_out !== exp_pc) begin n_errors++; $display("FAIL seq_pc: pc_out=%h expected %h", pc_out, exp_pc); end
    end
    pc_en = 0;
  endtask

  task automatic test_cold_taken();
    set_ex(32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    #1;
    n_checks++; if (flush !== 1'b1) begin n_errors++; $display("FAIL cold_flush: got %b expected 1", flush); end
    exp_q.push_back(32'h40);
    step();
    clear_ex();
    exp_pc = exp_q.pop_front();
    n_checks++; if (pc_out !== exp_pc) begin n_errors++; $display("FAIL cold_redirect: pc_out=%h expected %h", pc_out, exp_pc); end
    redirect_to(32'h10);
    n_checks++; if (pred_taken !== 1'b1) begin n_errors++; $display("FAIL cold_pred_taken: got %b expected 1", pred_taken); end
    n_checks++; if (pred_target !== 32'h40) begin n_errors++; $display("FAIL cold_pred_target: got %h expected %h", pred_target, 32'h40); end
    pc_en = 1;
    exp_q.push_back(32'h40);
    step();
    pc_en = 0;
    exp_pc = exp_q.pop_front();
    n_checks++; if (pc_out !== exp_pc) begin n_errors++; $display("FAIL cold_follow: pc_out=%h expected %h", pc_out, exp_pc); end
  endtask

  task automatic test_hysteresis();
    set_ex(32'h10, 1'b1, 32'h40, 1'b1, 32'h40);
    #1;
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL hyst_correct_flush: got %b expected 0", flush); end
    step();
    clear_ex();
    redirect_to(32'h10);
    for (int k = 0; k < 2; k++) begin
      set_ex(32'h10, 1'b0, 32'h40, 1'b1, 32'h40);
      #1;
      // Lookup in the update cycle still sees the pre-edge counter (strong, then weak taken).
      n_checks++; if (pred_taken !== 1'b1) begin n_errors++; $display("FAIL hyst_pre_edge: got %b expected 1", pred_taken); end
      exp_q.push_back(32'h14);
      step();
      clear_ex();
      exp_pc = exp_q.pop_front();
      n_checks++; if (pc_out !== exp_pc) begin n_errors++; $display("FAIL hyst_nt_redirect: pc_out=%h expected %h", pc_out, exp_pc); end
      redirect_to(32'h10);
    end
    n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL hyst_pred_taken: got %b expected 0", pred_taken); end
    n_checks++; if (pred_target !== 32'h14) begin n_errors++; $display("FAIL hyst_pred_target: got %h expected %h", pred_target, 32'h14); end
  endtask

  task automatic test_alias();
    set_ex(32'h10, 1'b1, 32'h40, 1'b0, 32'h14);
    exp_q.push_back(32'h40);
    step();
    clear_ex();
    exp_pc = exp_q.pop_front();
    n_checks++; if (pc_out !== exp_pc) begin n_errors++; $display("FAIL alias_train: pc_out=%h expected %h", pc_out, exp_pc); end
    redirect_to(32'h10);
    n_checks++; if (pred_taken !== 1'b1) begin n_errors++; $display("FAIL alias_before: got %b expected 1", pred_taken); end
    set_ex(32'h50, 1'b1, 32'h80, 1'b0, 32'h54);
    exp_q.push_back(32'h80);
    step();
    clear_ex();
    exp_pc = exp_q.pop_front();
    n_checks++; if (pc_out !== exp_pc) begin n_errors++; $display("FAIL alias_alloc: pc_out=%h expected %h", pc_out, exp_pc); end
    redirect_to(32'h10);
    n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL alias_evicted: got %b expected 0", pred_taken); end
    n_checks++; if (pred_target !== 32'h14) begin n_errors++; $display("FAIL alias_evicted_tgt: got %h expected %h", pred_target, 32'h14); end
    redirect_to(32'h50);
    n_checks++; if (pred_taken !== 1'b1) begin n_errors++; $display("FAIL alias_new: got %b expected 1", pred_taken); end
    n_checks++; if (pred_target !== 32'h80) begin n_errors++; $display("FAIL alias_new_tgt: got %h expected %h", pred_target, 32'h80); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      set_ex(32'h50, 1'b1, 32'h80, 1'b1, 32'h80);
      step();
    end
    set_ex(32'h50, 1'b0, 32'h80, 1'b1, 32'h80);
    step();
    clear_ex();
    redirect_to(32'h50);
    n_checks++; if (pred_taken !== 1'b1) begin n_errors++; $display("FAIL sat_top: got %b expected 1", pred_taken); end
    for (int k = 0; k < 3; k++) begin
      set_ex(32'h50, 1'b0, 32'h80, 1'b0, 32'h54);
      step();
    end
    set_ex(32'h50, 1'b1, 32'h80, 1'b1, 32'h80);
    step();
    clear_ex();
    n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL sat_bottom: got %b expected 0", pred_taken); end
    n_checks++; if (pc_out !== 32'h50) begin n_errors++; $display("FAIL sat_pc_hold: pc_out=%h expected %h", pc_out, 32'h50); end
  endtask

  task automatic test_priority();
    pc_en = 0; halt = 1;
    set_ex(32'h20, 1'b0, 32'h99, 1'b1, 32'h99);
    exp_q.push_back(32'h24);
    step();
    clear_ex();
    exp_pc = exp_q.pop_front();
    n_checks++; if (pc_out !== exp_pc) begin n_errors++; $display("FAIL prio_redirect: pc_out=%h expected %h", pc_out, exp_pc); end
    pc_en = 1;
    exp_q.push_back(32'h24);
    step();
    exp_pc = exp_q.pop_front();
    n_checks++; if (pc_out !== exp_pc) begin n_errors++; $display("FAIL prio_halt: pc_out=%h expected %h", pc_out, exp_pc); end
    pc_en = 0; halt = 0;
  endtask

  task automatic test_non_branch();
    ex_valid = 1; ex_is_branch = 0; ex_pc = 32'h24; ex_taken = 1; ex_target = 32'h200;
    ex_pred_taken = 0; ex_pred_target = 32'h28;
    #1;
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL nonbr_flush: got %b expected 0", flush); end
    ex_valid = 0; ex_is_branch = 1;
    #1;
    n_checks++; if (flush !== 1'b0) begin n_errors++; $display("FAIL bubble_flush: got %b expected 0", flush); end
    exp_q.push_back(32'h24);
    step();
    clear_ex();
    exp_pc = exp_q.pop_front();
    n_checks++; if (pc_out !== exp_pc) begin n_errors++; $display("FAIL nonbr_hold: pc_out=%h expected %h", pc_out, exp_pc); end
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFF_FFFC);
    n_checks++; if (pred_target !== 32'h0) begin n_errors++; $display("FAIL wrap_target: got %h expected %h", pred_target, 32'h0); end
    pc_en = 1;
    exp_q.push_back(32'h0);
    step();
    pc_en = 0;
    exp_pc = exp_q.pop_front();
    n_checks++; if (pc_out !== exp_pc) begin n_errors++; $display("FAIL wrap_pc: pc_out=%h expected %h", pc_out, exp_pc); end
  endtask

  task automatic test_reset_mid();
    redirect_to(32'h100);
    set_ex(32'h30, 1'b1, 32'h70, 1'b0, 32'h34);
    RST = 1;
    step();
    RST = 0;
    clear_ex();
    n_checks++; if (pc_out !== 32'h0) begin n_errors++; $display("FAIL mid_reset_pc: pc_out=%h expected %h", pc_out, 32'h0); end
    redirect_to(32'h30);
    n_checks++; if (pred_taken !== 1'b0) begin n_errors++; $display("FAIL mid_reset_update: got %b expected 0", pred_taken); end
  endtask

`ifdef BPU_STATS_EN
  task automatic test_stats();
    RST = 1;
    step();
    RST = 0;
    n_checks++; if (branch_cnt !== 32'h0) begin n_errors++; $display("FAIL stats_rst_br: got %0d expected 0", branch_cnt); end
    for (int k = 0; k < 3; k++) begin
      set_ex(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
      step();
    end
    ex_valid = 1; ex_is_branch = 0;
    step();
    for (int k = 0; k < 2; k++) begin
      set_ex(32'h100, 1'b0, 32'h0, 1'b1, 32'h300);
      step();
    end
    clear_ex();
    n_checks++; if (branch_cnt !== 32'd5) begin n_errors++; $display("FAIL stats_branch: got %0d expected 5", branch_cnt); end
    n_checks++; if (mispredict_cnt !== 32'd2) begin n_errors++; $display("FAIL stats_mispredict: got %0d expected 2", mispredict_cnt); end
    RST = 1;
    step();
    RST = 0;
    n_checks++; if (branch_cnt !== 32'h0) begin n_errors++; $display("FAIL stats_clr_br: got %0d expected 0", branch_cnt); end
    n_checks++; if (mispredict_cnt !== 32'h0) begin n_errors++; $display("FAIL stats_clr_mp: got %0d expected 0", mispredict_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_taken();
    test_hysteresis();
    test_alias();
    test_saturation();
    test_priority();
    test_non_branch();
    test_wrap();
    test_reset_mid();
`ifdef BPU_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
